// File: rtl/cache_ctrl_nway_if.sv
// Request, array-strobe and memory-engine signals of the N-way cache controller.
// The master side is the CPU/array/engine environment; the slave side is the controller.
interface cache_ctrl_nway_if #(
  parameter int WAYS = 4,
  parameter int SETS = 64
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);

  logic             req_valid;
  logic             req_rw;
  logic [SET_W-1:0] req_set;
  logic             resp_valid;
  logic             resp_hit;
  logic             busy;
  logic [WAYS-1:0]  way_match;
  logic [WAYS-1:0]  way_valid;
  logic [WAYS-1:0]  way_dirty;
  logic [WAY_W-1:0] sel_way;
  logic             tag_we;
  logic             valid_set;
  logic             data_we;
  logic             data_sel;
  logic             dirty_set;
  logic             dirty_clr;
  logic             wb_valid;
  logic             wb_ready;
  logic             wb_addr_sel;
  logic             ld_ready;
  logic             ld_valid;
  logic             mem_rw;
  logic             mem_addr_valid;

  modport master (
    output req_valid, req_rw, req_set, way_match, way_valid, way_dirty, wb_ready, ld_valid,
    input  resp_valid, resp_hit, busy, sel_way, tag_we, valid_set, data_we, data_sel,
           dirty_set, dirty_clr, wb_valid, wb_addr_sel, ld_ready, mem_rw, mem_addr_valid
  );

  modport slave (
    input  req_valid, req_rw, req_set, way_match, way_valid, way_dirty, wb_ready, ld_valid,
    output resp_valid, resp_hit, busy, sel_way, tag_we, valid_set, data_we, data_sel,
           dirty_set, dirty_clr, wb_valid, wb_addr_sel, ld_ready, mem_rw, mem_addr_valid
  );
endinterface

// File: rtl/cache_ctrl_nway.sv
// Control FSM for an N-way set-associative write-back cache: hit handling, true-LRU
// per set, victim choice, write-back / fill sequencing and optional write-around.
module cache_ctrl_nway #(
  parameter int WAYS        = 4,
  parameter int SETS        = 64,
  parameter bit WRITE_ALLOC = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  cache_ctrl_nway_if.slave bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);

  typedef enum logic [1:0] {LOOKUP, WB, LD, WT} state_e;

  state_e           state_q, state_d;
  logic             miss_q, miss_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] age_d [SETS][WAYS];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic             touch_en;
  logic [WAY_W-1:0] touch_way;

  // Victim: lowest-index invalid way, otherwise the least recently used one.
  always_comb begin
    hit        = |bus.way_match;
    hit_way    = '0;
    victim_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (bus.way_match[i]) hit_way = hit_way | WAY_W'(i);
      if (age_q[bus.req_set][i] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(i);
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!bus.way_valid[i]) victim_way = WAY_W'(i);
    end
  end

  // NOTE: every output and next-state signal gets a default before the case so no
  // path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d            = state_q;
    miss_d             = miss_q;
    victim_d           = victim_q;
    touch_en           = 1'b0;
    touch_way          = '0;
    bus.resp_valid     = 1'b0;
    bus.resp_hit       = 1'b0;
    bus.busy           = 1'b0;
    bus.sel_way        = '0;
    bus.tag_we         = 1'b0;
    bus.valid_set      = 1'b0;
    bus.data_we        = 1'b0;
    bus.data_sel       = 1'b0;
    bus.dirty_set      = 1'b0;
    bus.dirty_clr      = 1'b0;
    bus.wb_valid       = 1'b0;
    bus.wb_addr_sel    = 1'b0;
    bus.ld_ready       = 1'b0;
    bus.mem_rw         = 1'b0;
    bus.mem_addr_valid = 1'b0;
    // Outputs are held at 0 while reset is asserted, whatever the state or inputs.
    if (rst_n) begin
      bus.busy = (state_q != LOOKUP);
      unique case (state_q)
        LOOKUP: begin
          if (bus.req_valid && hit) begin
            bus.sel_way    = hit_way;
            bus.resp_valid = 1'b1;
            bus.resp_hit   = !miss_q;
            bus.data_we    = bus.req_rw;
            bus.dirty_set  = bus.req_rw;
            touch_en       = 1'b1;
            touch_way      = hit_way;
            miss_d         = 1'b0;
          end else if (bus.req_valid && (!bus.req_rw || WRITE_ALLOC)) begin
            victim_d = victim_way;
            miss_d   = 1'b1;
            state_d  = (bus.way_valid[victim_way] && bus.way_dirty[victim_way]) ? WB : LD;
          end else if (bus.req_valid) begin
            miss_d  = 1'b1;
            state_d = WT;
          end
        end
        WB: begin
          bus.sel_way        = victim_q;
          bus.wb_valid       = 1'b1;
          bus.wb_addr_sel    = 1'b1;
          bus.mem_rw         = 1'b1;
          bus.mem_addr_valid = 1'b1;
          if (bus.wb_ready) begin
            bus.dirty_clr = 1'b1;
            state_d       = LD;
          end
        end
        LD: begin
          bus.sel_way        = victim_q;
          bus.ld_ready       = 1'b1;
          bus.mem_addr_valid = 1'b1;
          if (bus.ld_valid) begin
            bus.tag_we    = 1'b1;
            bus.valid_set = 1'b1;
            bus.data_we   = 1'b1;
            bus.data_sel  = 1'b1;
            touch_en      = 1'b1;
            touch_way     = victim_q;
            state_d       = LOOKUP;
          end
        end
        WT: begin
          bus.wb_valid       = 1'b1;
          bus.mem_rw         = 1'b1;
          bus.mem_addr_valid = 1'b1;
          if (bus.wb_ready) begin
            bus.resp_valid = 1'b1;
            miss_d         = 1'b0;
            state_d        = LOOKUP;
          end
        end
        default: state_d = LOOKUP;
      endcase
    end
  end

  // True-LRU touch: younger ways age by one, the touched way becomes youngest.
  always_comb begin
    age_d = age_q;
    if (touch_en) begin
      for (int i = 0; i < WAYS; i++) begin
        if (age_q[bus.req_set][i] < age_q[bus.req_set][touch_way])
          age_d[bus.req_set][i] = age_q[bus.req_set][i] + WAY_W'(1);
      end
      age_d[bus.req_set][touch_way] = '0;
    end
  end

  // NOTE: the age array is reset on purpose: victim choice relies on every set holding
  // a valid permutation, so it cannot start from unknown contents like a data RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LOOKUP;
      miss_q   <= 1'b0;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int i = 0; i < WAYS; i++)
          age_q[s][i] <= WAY_W'(i);
    end else begin
      state_q  <= state_d;
      miss_q   <= miss_d;
      victim_q <= victim_d;
      age_q    <= age_d;
    end
  end
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for cache_ctrl_nway: hit, clean/dirty miss, invalid-way victim,
// write-around and mid-fill reset, with hand-computed expectations.
module tb_cache_ctrl_nway;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   wb_cnt;

  always #5 clk = ~clk;

  cache_ctrl_nway_if #(.WAYS(4), .SETS(16)) bus ();
  cache_ctrl_nway_if #(.WAYS(4), .SETS(16)) bus_wt ();

  cache_ctrl_nway #(.WAYS(4), .SETS(16), .WRITE_ALLOC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  cache_ctrl_nway #(.WAYS(4), .SETS(16), .WRITE_ALLOC(1'b0)) dut_wt (
    .clk(clk), .rst_n(rst_n), .bus(bus_wt.slave));

  always @(negedge clk)
    if (bus.req_valid) assert ($onehot0(bus.way_match)) else $error("way_match not one-hot");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ages of one set packed as {way3, way2, way1, way0}.
  function automatic logic [7:0] ages(input int s);
    return {dut.age_q[s][3], dut.age_q[s][2], dut.age_q[s][1], dut.age_q[s][0]};
  endfunction

  function automatic logic [7:0] ages_wt(input int s);
    return {dut_wt.age_q[s][3], dut_wt.age_q[s][2], dut_wt.age_q[s][1], dut_wt.age_q[s][0]};
  endfunction

  task automatic drive(input logic v, input logic rw, input logic [3:0] set,
                       input logic [3:0] match, input logic [3:0] valid, input logic [3:0] dirty);
    bus.req_valid = v;
    bus.req_rw    = rw;
    bus.req_set   = set;
    bus.way_match = match;
    bus.way_valid = valid;
    bus.way_dirty = dirty;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wb_ready = 1'b0;    bus.ld_valid = 1'b0;
    bus_wt.req_valid = 1'b0; bus_wt.req_rw = 1'b0; bus_wt.req_set = '0;
    bus_wt.way_match = '0;   bus_wt.way_valid = '0; bus_wt.way_dirty = '0;
    bus_wt.wb_ready = 1'b0;  bus_wt.ld_valid = 1'b0;
    drive(1'b1, 1'b0, 4'd3, 4'b0100, 4'b1111, 4'b0000);
    check("rst_resp_gated", {31'd0, bus.resp_valid}, 32'd0);
    step();
    step();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_ages", {24'd0, ages(3)}, 32'h0000_00E4);
    rst_n = 1'b1;

    // Read hit on way 2 of set 3.
    drive(1'b1, 1'b0, 4'd3, 4'b0100, 4'b1111, 4'b0000);
    check("hit_resp", {30'd0, bus.resp_valid, bus.resp_hit}, 32'd3);
    check("hit_no_we", {29'd0, bus.data_we, bus.sel_way}, 32'd2);
    step();
    drive(1'b0, 1'b0, 4'd3, 4'b0000, 4'b1111, 4'b0000);
    check("hit_lru", {24'd0, ages(3)}, 32'h0000_00C9);

    // Clean read miss in set 5, fill after four LD cycles.
    drive(1'b1, 1'b0, 4'd5, 4'b0000, 4'b1111, 4'b0000);
    check("rmiss_lookup", {30'd0, bus.busy, bus.resp_valid}, 32'd0);
    step();
    check("rmiss_ld", {26'd0, bus.busy, bus.ld_ready, bus.mem_addr_valid, bus.mem_rw, bus.sel_way}, 32'b1110_11);
    for (int k = 0; k < 3; k++) begin
      check("rmiss_ld_wait", {30'd0, bus.tag_we, bus.ld_ready}, 32'd1);
      step();
    end
    bus.ld_valid = 1'b1; #1;
    check("rmiss_fill", {26'd0, bus.tag_we, bus.valid_set, bus.data_we, bus.data_sel, bus.sel_way}, 32'b1111_11);
    step();
    bus.ld_valid = 1'b0;
    drive(1'b1, 1'b0, 4'd5, 4'b1000, 4'b1111, 4'b0000);
    check("rmiss_resp", {27'd0, bus.busy, bus.resp_valid, bus.resp_hit, bus.sel_way}, 32'b0_10_11);
    step();
    drive(1'b0, 1'b0, 4'd5, 4'b0000, 4'b1111, 4'b0000);
    check("rmiss_lru", {24'd0, ages(5)}, 32'h0000_0039);

    // Write miss with dirty victim (way 3), wb_ready after 6 wait cycles.
    drive(1'b1, 1'b1, 4'd7, 4'b0000, 4'b1111, 4'b1000);
    step();
    wb_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      bus.wb_ready = (k == 6);
      bus.ld_valid = (k == 6);
      #1;
      wb_cnt += int'(bus.wb_valid);
      check("wb_clr", {28'd0, bus.dirty_clr, bus.wb_addr_sel, bus.mem_rw, bus.ld_ready},
            {28'd0, (k == 6), 3'b110});
      step();
    end
    check("wb_cycles", wb_cnt, 32'd7);
    bus.wb_ready = 1'b0;
    bus.ld_valid = 1'b0; #1;
    check("wb_to_ld", {29'd0, bus.ld_ready, bus.wb_valid, bus.tag_we}, 32'b100);
    step();
    bus.ld_valid = 1'b1; #1;
    check("wb_fill", {29'd0, bus.tag_we, bus.data_sel, bus.dirty_clr}, 32'b110);
    step();
    bus.ld_valid = 1'b0;
    drive(1'b1, 1'b1, 4'd7, 4'b1000, 4'b1111, 4'b0000);
    check("wb_merge", {27'd0, bus.resp_valid, bus.resp_hit, bus.dirty_set, bus.data_we, bus.data_sel},
          32'b10110);
    step();
    drive(1'b0, 1'b0, 4'd7, 4'b0000, 4'b1111, 4'b0000);
    check("wb_lru", {24'd0, ages(7)}, 32'h0000_0039);

    // Invalid way 2 beats the LRU way 3 as victim.
    drive(1'b1, 1'b0, 4'd9, 4'b0000, 4'b1011, 4'b1111);
    step();
    check("inv_victim", {29'd0, bus.wb_valid, bus.sel_way}, 32'd2);
    bus.ld_valid = 1'b1; #1;
    step();
    bus.ld_valid = 1'b0;
    drive(1'b1, 1'b0, 4'd9, 4'b0100, 4'b1111, 4'b0000);
    check("inv_resp", {30'd0, bus.resp_valid, bus.resp_hit}, 32'd2);
    step();
    check("inv_rehit", {30'd0, bus.resp_valid, bus.resp_hit}, 32'd3);
    step();
    drive(1'b0, 1'b0, 4'd9, 4'b0000, 4'b1111, 4'b0000);
    check("inv_lru", {24'd0, ages(9)}, 32'h0000_00C9);

    // Write-around on the WRITE_ALLOC=0 instance.
    bus_wt.req_valid = 1'b1; bus_wt.req_rw = 1'b1; bus_wt.req_set = 4'd4;
    bus_wt.way_valid = 4'b1111; #1;
    step();
    check("wt_state", {27'd0, bus_wt.busy, bus_wt.wb_valid, bus_wt.wb_addr_sel, bus_wt.mem_rw,
                       bus_wt.resp_valid}, 32'b11010);
    step();
    bus_wt.wb_ready = 1'b1; #1;
    check("wt_resp", {26'd0, bus_wt.resp_valid, bus_wt.resp_hit, bus_wt.tag_we, bus_wt.data_we,
                      bus_wt.dirty_set, bus_wt.ld_ready}, 32'b100000);
    step();
    bus_wt.wb_ready = 1'b0;
    bus_wt.req_valid = 1'b0; #1;
    check("wt_done", {30'd0, bus_wt.busy, bus_wt.wb_valid}, 32'd0);
    check("wt_lru", {24'd0, ages_wt(4)}, 32'h0000_00E4);

    // Reset in the middle of a fill.
    drive(1'b1, 1'b0, 4'd11, 4'b0000, 4'b1111, 4'b0000);
    step();
    check("rst_ld_pre", {31'd0, bus.ld_ready}, 32'd1);
    rst_n = 1'b0; #1;
    check("rst_ld_gated", {31'd0, bus.ld_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 4'd11, 4'b0000, 4'b1111, 4'b0000);
    check("rst_ld_idle", {28'd0, bus.busy, bus.ld_ready, bus.mem_addr_valid, bus.wb_valid}, 32'd0);
    check("rst_ld_ages", {24'd0, ages(3)}, 32'h0000_00E4);
    drive(1'b1, 1'b0, 4'd11, 4'b0000, 4'b1111, 4'b0000);
    step();
    check("rst_fresh_ld", {29'd0, bus.ld_ready, bus.sel_way}, 32'b111);
    bus.ld_valid = 1'b1; #1;
    step();
    bus.ld_valid = 1'b0;
    drive(1'b1, 1'b0, 4'd11, 4'b1000, 4'b1111, 4'b0000);
    check("rst_fresh_resp", {30'd0, bus.resp_valid, bus.resp_hit}, 32'd2);
    step();
    drive(1'b0, 1'b0, 4'd11, 4'b0000, 4'b1111, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_nway.md
# cache_ctrl_nway

Parametrised control FSM for an N-way set-associative, write-back cache core. It sits between the CPU request port, the per-way tag/data/dirty arrays, and the AXI-4 write-back and load engines. It owns true-LRU state per set and victim selection. It supports write-allocate or write-no-allocate (write-around) on write misses.

## Interface
- `WAYS`, 4: associativity; power of 2, range 2..8; `WAY_W = $clog2(WAYS)`.
- `SETS`, 64: number of sets; power of 2; `SET_W = $clog2(SETS)`.
- `WRITE_ALLOC`, 1: 1 = write miss allocates the line; 0 = write miss goes straight to memory, no fill.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  CPU request present; held with `req_rw`/`req_set` stable until `resp_valid`
- `req_rw`  in  1  1 = write, 0 = read
- `req_set`  in  SET_W  set index of the request
- `resp_valid`  out  1  one-cycle pulse; request complete
- `resp_hit`  out  1  qualifies `resp_valid`; 1 = first lookup hit
- `busy`  out  1  FSM is not in LOOKUP
- `way_match`  in  WAYS  per-way tag-compare result for `req_set`; one-hot or zero
- `way_valid`  in  WAYS  per-way valid bits for `req_set`
- `way_dirty`  in  WAYS  per-way dirty bits for `req_set`
- `sel_way`  out  WAY_W  way addressed by all array strobes
- `tag_we`, `valid_set`  out  1  write the tag and set valid on `sel_way`
- `data_we`  out  1  write data on `sel_way`
- `data_sel`  out  1  0 = CPU write data, 1 = fill data
- `dirty_set`, `dirty_clr`  out  1  dirty-bit strobes on `sel_way`
- `wb_valid`  out  1  write request to the write-back engine
- `wb_ready`  in  1  write-back engine done
- `wb_addr_sel`  out  1  0 = request address/CPU data, 1 = victim tag/line
- `ld_ready`  out  1  load request to the load engine
- `ld_valid`  in  1  fill data is available this cycle
- `mem_rw`  out  1  1 = memory write, 0 = memory read
- `mem_addr_valid`  out  1  memory address is valid

## Operation
- States: LOOKUP, WB, LD, WT.
- Reset state is LOOKUP. Reset is allowed in any state, mid-transaction. Reset does the following:
  - clears `miss_q` and `victim_q`;
  - sets `age[s][i] = i` for every set s and way i;
  - drives all outputs to 0.
- LOOKUP with `req_valid` and `way_match` = way h (hit):
  - `sel_way = h`, `resp_valid = 1`, `resp_hit = !miss_q`;
  - on a write, also `data_we = 1`, `data_sel = 0`, `dirty_set = 1`;
  - touch way h in the LRU; clear `miss_q`; stay in LOOKUP.
- LOOKUP with `req_valid` and `way_match = 0` (miss), write-allocate path (read miss, or `WRITE_ALLOC = 1`):
  - victim = lowest-index way with `way_valid = 0`; if every way is valid, victim = way with `age = WAYS-1`;
  - latch the victim into `victim_q`; set `miss_q`;
  - next state is WB if the victim is valid and dirty, otherwise LD.
- LOOKUP write miss with `WRITE_ALLOC = 0`: set `miss_q`, go to WT.
- WB:
  - drive `sel_way = victim_q`, `wb_valid = 1`, `wb_addr_sel = 1`, `mem_rw = 1`, `mem_addr_valid = 1`;
  - on `wb_ready`: pulse `dirty_clr`, go to LD.
- LD:
  - drive `sel_way = victim_q`, `ld_ready = 1`, `mem_addr_valid = 1`;
  - on `ld_valid`: pulse `tag_we`, `valid_set`, `data_we` with `data_sel = 1`; touch `victim_q` in the LRU; go to LOOKUP.
  - The held request re-looks-up and hits, which produces the response with `resp_hit = 0`; a write merges on that hit.
- WT:
  - drive `wb_valid = 1`, `wb_addr_sel = 0`, `mem_rw = 1`, `mem_addr_valid = 1`;
  - on `wb_ready`: `resp_valid = 1`, `resp_hit = 0`, clear `miss_q`, go to LOOKUP; no array strobes, no LRU touch.
- LRU touch of way w in set s:
  - every way with `age < age[w]` increments by 1, and `age[w]` becomes 0;
  - ages stay a permutation of 0..WAYS-1 and never wrap.
- LOOKUP without `req_valid`: all strobes are 0, no state change.
- A `way_match` with more than one bit set is illegal; behaviour is undefined and the bench flags it with an assertion.

## Timing
- All strobes and handshake outputs are combinational from state and inputs; LRU, `victim_q`, `miss_q` and state update on the rising edge.
- `busy` is 0 in LOOKUP, 1 in all other states.
- Hit latency: `resp_valid` in the same cycle as the LOOKUP with `req_valid`; the LRU update is visible on the next cycle.
- Clean-miss read: 1 cycle LOOKUP, then LD until `ld_valid`, then 1 cycle LOOKUP for the response. Minimum is 3 cycles.
- Dirty miss: adds WB cycles until `wb_ready`. Minimum is 4 cycles.
- `wb_valid` and `ld_ready` stay high until their partner is seen. Partner inputs asserted in other states are ignored.
- `ld_valid` in the same cycle as the WB→LD transition is not sampled; LD samples from its first cycle.

## Test plan
- WAYS=4, SETS=16, reset, read hit on way 2 of set 3 → `resp_valid = resp_hit = 1` in the same cycle, `data_we = 0`. `age[3]` changes from {0,1,2,3} to {1,2,0,3}.
- Read miss in set 5 with all ways valid and clean → victim = way 3. LD held for 4 cycles, `ld_valid` → fill on way 3. The next cycle gives `resp_valid = 1`, `resp_hit = 0`, and `age[5][3] = 0`.
- Write miss with victim dirty, `wb_ready` delayed 6 cycles → `wb_valid` high for 7 cycles, then `dirty_clr`, then LD, fill, and a merge hit with `dirty_set = 1`, `resp_hit = 0`.
- Miss with `way_valid = 4'b1011` → victim = way 2 (the invalid way), regardless of ages.
- `WRITE_ALLOC = 0`, write miss → WT with `wb_addr_sel = 0`. On `wb_ready`: `resp_valid = 1`, `resp_hit = 0`, no `tag_we`/`data_we`, ages unchanged.
- `rst_n` low during LD → the next cycle is LOOKUP with all outputs 0 and ages reinitialised; a subsequent fresh request completes normally.
